// File: rtl/mb8_result_checker.sv
// Response checker for the radix-8 Booth multiplier: predicts mx*my, delays it to match the
// multiplier latency, compares against product and keeps saturating counts plus a first-error capture.
module mb8_result_checker #(
    parameter int WIDTH = 8,
    parameter int LAT   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     mx,
    input  logic [WIDTH-1:0]     my,
    input  logic [2*WIDTH-1:0]   product,
    input  logic                 clear,
    output logic [CNT_W-1:0]     cmp_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 err_pulse,
    output logic                 err_flag,
    output logic [2*WIDTH-1:0]   first_err_exp,
    output logic [2*WIDTH-1:0]   first_err_got,
    output logic [CNT_W-1:0]     first_err_idx
);

    localparam int              PW      = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage k holds the vector sampled k edges ago; stage LAT meets product at the next edge.
    logic [LAT:0]  pipe_vld;
    logic [PW-1:0] pipe_exp [LAT+1];

    logic cmp_hit;
    logic mismatch;

    // NOTE: state registers use non-blocking assignments so every stage shifts from pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld <= {pipe_vld[LAT-1:0], in_valid};
        end
    end

    // NOTE: the expected-value data path needs no reset; only the valid bits decide what is compared.
    always_ff @(posedge CLK) begin
        if (in_valid) begin
            pipe_exp[0] <= PW'(mx) * PW'(my);
        end
        for (int k = 1; k <= LAT; k++) begin
            pipe_exp[k] <= pipe_exp[k-1];
        end
    end

    assign cmp_hit  = pipe_vld[LAT];
    assign mismatch = cmp_hit && (product != pipe_exp[LAT]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cmp_cnt       <= '0;
            err_cnt       <= '0;
            err_pulse     <= 1'b0;
            err_flag      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            first_err_idx <= '0;
        end else if (clear) begin
            // Clear discards any comparison landing on the same edge.
            cmp_cnt       <= '0;
            err_cnt       <= '0;
            err_pulse     <= 1'b0;
            err_flag      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            first_err_idx <= '0;
        end else begin
            err_pulse <= mismatch;
            if (cmp_hit && (cmp_cnt != CNT_MAX)) begin
                cmp_cnt <= cmp_cnt + CNT_W'(1);
            end
            if (mismatch) begin
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
                if (!err_flag) begin
                    err_flag      <= 1'b1;
                    first_err_exp <= pipe_exp[LAT];
                    first_err_got <= product;
                    first_err_idx <= cmp_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mb8_result_checker.sv
// Directed bench for mb8_result_checker: a 16-bit-counter instance and a 4-bit-counter instance
// share the same stimulus; product values are scheduled LAT+1 edges after their vector.
module tb_mb8_result_checker;

    localparam int LAT = 4;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic [7:0]  mx;
    logic [7:0]  my;
    logic [15:0] product;
    logic        clear;

    logic [15:0] cmp_cnt, err_cnt, first_err_idx;
    logic        err_pulse, err_flag;
    logic [15:0] first_err_exp, first_err_got;

    logic [3:0]  s_cmp_cnt, s_err_cnt, s_first_err_idx;
    logic        s_err_pulse, s_err_flag;
    logic [15:0] s_first_err_exp, s_first_err_got;

    mb8_result_checker #(.WIDTH(8), .LAT(LAT), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .mx(mx), .my(my),
        .product(product), .clear(clear),
        .cmp_cnt(cmp_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse), .err_flag(err_flag),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got),
        .first_err_idx(first_err_idx)
    );

    mb8_result_checker #(.WIDTH(8), .LAT(LAT), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .mx(mx), .my(my),
        .product(product), .clear(clear),
        .cmp_cnt(s_cmp_cnt), .err_cnt(s_err_cnt), .err_pulse(s_err_pulse), .err_flag(s_err_flag),
        .first_err_exp(s_first_err_exp), .first_err_got(s_first_err_got),
        .first_err_idx(s_first_err_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;
    int slot   = 0;
    logic [15:0] sched [0:1023];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the negedge, schedule the product for the compare edge,
    // then return at the following negedge so outputs are sampled mid-cycle.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p);
        in_valid = v;
        mx       = a;
        my       = b;
        if (v) sched[slot + LAT + 1] = p;
        product  = sched[slot];
        @(posedge CLK);
        slot++;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 8'h00, 16'h0000);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        logic [7:0]  a, b;
        logic [15:0] p;

        RST = 1'b0; in_valid = 1'b0; mx = '0; my = '0; product = '0; clear = 1'b0;
        for (int i = 0; i < 1024; i++) sched[i] = 16'hDEAD;

        #3;
        check("reset cmp_cnt", 32'(cmp_cnt), 0);
        check("reset err_flag", 32'(err_flag), 0);
        check("reset err_pulse", 32'(err_pulse), 0);
        @(negedge CLK);
        RST = 1'b1;

        // Pair match: 0x12*0x34 = 0x03A8, counted at edge t0+5 and not before.
        step(1'b1, 8'h12, 8'h34, 16'h03A8);
        idle(4);
        check("match early cmp_cnt", 32'(cmp_cnt), 0);
        idle(1);
        check("match cmp_cnt", 32'(cmp_cnt), 1);
        check("match err_cnt", 32'(err_cnt), 0);
        check("match err_flag", 32'(err_flag), 0);

        // Single mismatch: exp 0xFE01, product 0xFE00.
        pulse_clear();
        check("clear cmp_cnt", 32'(cmp_cnt), 0);
        step(1'b1, 8'hFF, 8'hFF, 16'hFE00);
        idle(4);
        check("mis pulse early", 32'(err_pulse), 0);
        idle(1);
        check("mis err_pulse", 32'(err_pulse), 1);
        check("mis err_cnt", 32'(err_cnt), 1);
        check("mis err_flag", 32'(err_flag), 1);
        check("mis first_err_exp", 32'(first_err_exp), 32'hFE01);
        check("mis first_err_got", 32'(first_err_got), 32'hFE00);
        check("mis first_err_idx", 32'(first_err_idx), 0);
        idle(1);
        check("mis pulse drop", 32'(err_pulse), 0);
        check("mis flag sticky", 32'(err_flag), 1);

        // Streaming with bubbles: 10 valid, 5 bubbles whose product slots hold 0xDEAD.
        pulse_clear();
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 2) begin
                idle(1);
            end else begin
                a = 8'(i * 17 + 3);
                b = 8'(255 - i * 13);
                p = {8'h00, a} * {8'h00, b};
                step(1'b1, a, b, p);
            end
        end
        idle(LAT + 2);
        check("stream cmp_cnt", 32'(cmp_cnt), 10);
        check("stream err_cnt", 32'(err_cnt), 0);
        check("stream err_flag", 32'(err_flag), 0);

        // 20 consecutive mismatches; the 4-bit instance saturates at 15.
        pulse_clear();
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            a = 8'(i + 1);
            p = ({8'h00, a} * 16'd3) ^ 16'h0001;
            step(1'b1, a, 8'd3, p);
            if (s_err_pulse) hi++;
        end
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (s_err_pulse) hi++;
        end
        check("sat pulse cycles", 32'(hi), 20);
        check("sat err_pulse end", 32'(s_err_pulse), 0);
        check("sat err_cnt", 32'(s_err_cnt), 15);
        check("sat cmp_cnt", 32'(s_cmp_cnt), 15);
        check("sat first_err_idx", 32'(s_first_err_idx), 0);
        check("sat first_err_exp", 32'(s_first_err_exp), 3);
        check("sat first_err_got", 32'(s_first_err_got), 2);
        check("wide err_cnt", 32'(err_cnt), 20);
        check("wide cmp_cnt", 32'(cmp_cnt), 20);

        // Clear collides with a mismatching compare; the next in-flight vector still counts.
        pulse_clear();
        step(1'b1, 8'd5, 8'd7, 16'h0000);
        step(1'b1, 8'd6, 8'd7, 16'd42);
        idle(3);
        pulse_clear();
        check("coll cmp_cnt", 32'(cmp_cnt), 0);
        check("coll err_cnt", 32'(err_cnt), 0);
        check("coll err_flag", 32'(err_flag), 0);
        check("coll err_pulse", 32'(err_pulse), 0);
        idle(1);
        check("coll next cmp_cnt", 32'(cmp_cnt), 1);
        check("coll next err_cnt", 32'(err_cnt), 0);

        // Reset mid-flight: three mismatching vectors are aborted.
        step(1'b1, 8'd9, 8'd9, 16'h0001);
        step(1'b1, 8'd10, 8'd9, 16'h0002);
        step(1'b1, 8'd11, 8'd9, 16'h0003);
        idle(1);
        RST = 1'b0;
        #2;
        check("rst async cmp_cnt", 32'(cmp_cnt), 0);
        #1;
        idle(1);
        check("rst low err_flag", 32'(err_flag), 0);
        RST = 1'b1;
        idle(LAT + 4);
        check("rst after cmp_cnt", 32'(cmp_cnt), 0);
        check("rst after err_cnt", 32'(err_cnt), 0);
        check("rst after err_flag", 32'(err_flag), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
